// File: rtl/pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_flow_ctrl
//   Central stall/flush scheduler for the five-stage pipeline. Combines the
//   hazard unit's raw stall requests with the mult/div busy window, and gives
//   exception/interrupt flushes priority over every stall.
//
//   Optional build macro: PIPE_STALL_STATS_EN
//     Adds the saturating stall_cycles / flush_count statistics ports.
// -----------------------------------------------------------------------------
module pipe_flow_ctrl #(
  parameter int MULT_LAT = 5,   // MDU busy cycles after mult/multu
  parameter int DIV_LAT  = 10,  // MDU busy cycles after div/divu
  parameter int CNT_W    = 4    // must hold max(MULT_LAT, DIV_LAT)
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low
  input  logic             d_hazard,
  input  logic             d_md_use,
  input  logic             e_md_start,
  input  logic             e_md_is_div,
  input  logic             m_exc_req,
  output logic             f_en,
  output logic             fd_en,
  output logic             fd_stall,
  output logic             de_bubble,
  output logic             flush_req,
  output logic             md_busy,
  output logic [CNT_W-1:0] busy_cnt
`ifdef PIPE_STALL_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,  // MDU idle
    ST_MDBUSY = 2'd1,  // busy window running
    ST_EXCQ   = 2'd2   // single cycle after a flush; D holds a bubble
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_busy_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_start;
  logic             w_md_stall;
  logic             w_stall;
  logic             w_flush;

  // A start cancelled by a same-cycle flush never loads the counter.
  assign w_start = e_md_start && !m_exc_req;

  // Next busy count: load on accepted start, otherwise count down to zero.
  always_comb begin
    // NOTE: default assignment first so every path drives w_cnt_next and no latch is inferred.
    w_cnt_next = r_busy_cnt;
    if (w_start)
      w_cnt_next = e_md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (r_busy_cnt != '0)
      w_cnt_next = r_busy_cnt - 1'b1;
  end

  // Stall/flush resolution; flush wins, and EXCQ suppresses stalls because D is a bubble.
  always_comb begin
    w_flush    = reset && m_exc_req;
    w_md_stall = d_md_use && ((r_busy_cnt != '0) || w_start);
    w_stall    = reset && (d_hazard || w_md_stall) && !m_exc_req
                 && (r_state != ST_EXCQ);
  end

  // Flow-control state and MDU busy counter; an in-flight op keeps counting through a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
      r_state    <= ST_RUN;
      r_busy_cnt <= '0;
    end else begin
      r_busy_cnt <= w_cnt_next;
      if (m_exc_req)
        r_state <= ST_EXCQ;
      else if (w_cnt_next != '0)
        r_state <= ST_MDBUSY;
      else
        r_state <= ST_RUN;
    end
  end

  assign fd_stall  = w_stall;
  assign de_bubble = w_stall;
  assign fd_en     = !w_stall;
  assign f_en      = !w_stall || w_flush;  // PC must load the handler address on flush
  assign flush_req = w_flush;
  assign md_busy   = (r_busy_cnt != '0);
  assign busy_cnt  = r_busy_cnt;

  // The hazard rule keeps D from issuing a start while the MDU is still busy.
  assert property (@(posedge clk) disable iff (!reset)
                   !(w_start && (r_busy_cnt != '0)));

`ifdef PIPE_STALL_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  // Saturating stall-cycle and flush-event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (m_exc_req && (r_flush_count != 16'hFFFF))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_flow_ctrl
//   Self-checking bench for pipe_flow_ctrl. Every driven cycle pushes the
//   model's expected outputs to a scoreboard queue; a negedge monitor pops and
//   compares. Each scenario task adds its own directed inline comparisons.
// -----------------------------------------------------------------------------
module tb_pipe_flow_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             d_hazard = 1'b0;
  logic             d_md_use = 1'b0;
  logic             e_md_start = 1'b0;
  logic             e_md_is_div = 1'b0;
  logic             m_exc_req = 1'b0;
  logic             f_en;
  logic             fd_en;
  logic             fd_stall;
  logic             de_bubble;
  logic             flush_req;
  logic             md_busy;
  logic [CNT_W-1:0] busy_cnt;
`ifdef PIPE_STALL_STATS_EN
  logic [31:0]      stall_cycles;
  logic [15:0]      flush_count;
`endif

  pipe_flow_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .d_hazard    (d_hazard),
    .d_md_use    (d_md_use),
    .e_md_start  (e_md_start),
    .e_md_is_div (e_md_is_div),
    .m_exc_req   (m_exc_req),
    .f_en        (f_en),
    .fd_en       (fd_en),
    .fd_stall    (fd_stall),
    .de_bubble   (de_bubble),
    .flush_req   (flush_req),
    .md_busy     (md_busy),
    .busy_cnt    (busy_cnt)
`ifdef PIPE_STALL_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       f_en;
    logic       fd_en;
    logic       fd_stall;
    logic       de_bubble;
    logic       flush_req;
    logic       md_busy;
    logic [3:0] busy_cnt;
  } exp_t;

  exp_t  sb_q[$];
  string sb_tag[$];
  int    n_vec  = 0;
  int    n_miss = 0;
  string cur_test = "init";

  // Reference model state (behavioural, updated at each posedge)
  int    m_cnt  = 0;
  bit    m_excq = 1'b0;
  bit    m_last_stall = 1'b0;
  longint m_stall_cnt = 0;
  int    m_flush_cnt = 0;

  function automatic exp_t model_expect();
    exp_t e;
    bit   st, mdst, stall;
    if (!reset) begin
      e = '{f_en: 1'b1, fd_en: 1'b1, fd_stall: 1'b0, de_bubble: 1'b0,
            flush_req: 1'b0, md_busy: 1'b0, busy_cnt: 4'd0};
      return e;
    end
    st    = e_md_start && !m_exc_req;
    mdst  = d_md_use && (m_cnt != 0 || st);
    stall = (d_hazard || mdst) && !m_exc_req && !m_excq;
    e.f_en      = !stall || m_exc_req;
    e.fd_en     = !stall;
    e.fd_stall  = stall;
    e.de_bubble = stall;
    e.flush_req = m_exc_req;
    e.md_busy   = (m_cnt != 0);
    e.busy_cnt  = 4'(m_cnt);
    return e;
  endfunction

  task automatic model_update();
    if (!reset) begin
      m_cnt = 0;
      m_excq = 1'b0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (m_last_stall) m_stall_cnt++;
      if (m_exc_req) m_flush_cnt++;
      if (e_md_start && !m_exc_req)
        m_cnt = e_md_is_div ? 10 : 5;
      else if (m_cnt > 0)
        m_cnt--;
      m_excq = m_exc_req;
    end
  endtask

  // One pipeline cycle: advance model at the edge, then drive and log the expectation.
  task automatic drive(input bit rst, input bit haz, input bit use_md,
                       input bit start, input bit is_div, input bit exc);
    exp_t e;
    @(posedge clk);
    model_update();
    #1;
    if (m_cnt != 0) start = 1'b0;  // keep stimulus legal: no start while busy
    reset       = rst;
    d_hazard    = haz;
    d_md_use    = use_md;
    e_md_start  = start;
    e_md_is_div = is_div;
    m_exc_req   = exc;
    e = model_expect();
    m_last_stall = e.fd_stall;
    sb_q.push_back(e);
    sb_tag.push_back(cur_test);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0);
  endtask

  // Scoreboard monitor
  exp_t  mon_exp, mon_obs;
  string mon_tag;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      mon_tag = sb_tag.pop_front();
      mon_obs = '{f_en: f_en, fd_en: fd_en, fd_stall: fd_stall, de_bubble: de_bubble,
                  flush_req: flush_req, md_busy: md_busy, busy_cnt: busy_cnt};
      n_vec++;
      if (mon_obs !== mon_exp) begin
        n_miss++;
        $display("FAIL sb_%s @%0t: observed %b required %b (f_en fd_en fd_stall de_bubble flush md_busy cnt[3:0])",
                 mon_tag, $time, mon_obs, mon_exp);
      end
    end
  end

  task automatic test_reset();
    cur_test = "reset";
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(0, 1, 1, 1, 0, 1);
      else        drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      n_vec++;
      if (busy_cnt !== 4'd0 || fd_en !== 1'b1 || f_en !== 1'b1 || flush_req !== 1'b0 || fd_stall !== 1'b0) begin
        n_miss++;
        $display("FAIL reset_hold cyc%0d: observed cnt=%0d fd_en=%b f_en=%b flush=%b stall=%b required 0 1 1 0 0",
                 i, busy_cnt, fd_en, f_en, flush_req, fd_stall);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_vec++;
      if (busy_cnt !== 4'd0) begin
        n_miss++;
        $display("FAIL reset_release cyc%0d: observed cnt=%0d required 0", i, busy_cnt);
      end
    end
  endtask

  task automatic test_mult_mflo();
    cur_test = "mult_mflo";
    for (int k = 0; k <= 6; k++) begin
      drive(1, 0, 1, (k == 0), 0, 0);
      @(negedge clk);
      n_vec++;
      if (fd_stall !== (k < 6)) begin
        n_miss++;
        $display("FAIL mult_stall cyc%0d: observed %b required %b", k, fd_stall, (k < 6));
      end
      if (k >= 1) begin
        n_vec++;
        if (busy_cnt !== 4'(6 - k)) begin
          n_miss++;
          $display("FAIL mult_cnt cyc%0d: observed %0d required %0d", k, busy_cnt, 6 - k);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_div();
    int busy_cycles;
    cur_test = "div";
    busy_cycles = 0;
    drive(1, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 13; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (k == 1) begin
        n_vec++;
        if (busy_cnt !== 4'd10) begin
          n_miss++;
          $display("FAIL div_load: observed %0d required 10", busy_cnt);
        end
      end
      if (md_busy === 1'b1) busy_cycles++;
    end
    n_vec++;
    if (busy_cycles != 10) begin
      n_miss++;
      $display("FAIL div_busy_len: observed %0d required 10", busy_cycles);
    end
  endtask

  task automatic test_load_use();
    cur_test = "load_use";
    drive(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if ({fd_stall, de_bubble, fd_en, f_en} !== 4'b1100) begin
      n_miss++;
      $display("FAIL load_use_stall: observed %b required 1100", {fd_stall, de_bubble, fd_en, f_en});
    end
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if ({fd_stall, de_bubble, fd_en, f_en} !== 4'b0011) begin
      n_miss++;
      $display("FAIL load_use_release: observed %b required 0011", {fd_stall, de_bubble, fd_en, f_en});
    end
  endtask

  task automatic test_flush_priority();
    cur_test = "flush_prio";
    drive(1, 1, 0, 1, 0, 1);
    @(negedge clk);
    n_vec++;
    if ({flush_req, fd_stall, f_en} !== 3'b101) begin
      n_miss++;
      $display("FAIL flush_prio: observed flush/stall/f_en=%b required 101", {flush_req, fd_stall, f_en});
    end
    drive(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (busy_cnt !== 4'd0 || fd_stall !== 1'b0) begin
      n_miss++;
      $display("FAIL flush_excq: observed cnt=%0d stall=%b required 0 0", busy_cnt, fd_stall);
    end
    drive(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (fd_stall !== 1'b1) begin
      n_miss++;
      $display("FAIL flush_after_excq: observed stall=%b required 1", fd_stall);
    end
    idle(1);
  endtask

  task automatic test_flush_busy();
    cur_test = "flush_busy";
    drive(1, 0, 0, 1, 0, 0);
    idle(2);
    drive(1, 0, 1, 0, 0, 1);
    @(negedge clk);
    n_vec++;
    if (busy_cnt !== 4'd3 || flush_req !== 1'b1 || fd_stall !== 1'b0) begin
      n_miss++;
      $display("FAIL flush_busy_at3: observed cnt=%0d flush=%b stall=%b required 3 1 0", busy_cnt, flush_req, fd_stall);
    end
    for (int k = 2; k >= 0; k--) begin
      drive(1, 0, 1, 0, 0, 0);
      @(negedge clk);
      n_vec++;
      if (busy_cnt !== 4'(k) || fd_stall !== (k == 1)) begin
        n_miss++;
        $display("FAIL flush_busy_cnt%0d: observed cnt=%0d stall=%b required %0d %b", k, busy_cnt, fd_stall, k, (k == 1));
      end
    end
    idle(1);
  endtask

  task automatic test_reset_mid_busy();
    cur_test = "reset_mid_busy";
    drive(1, 0, 0, 1, 1, 0);
    idle(2);
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (busy_cnt !== 4'd0 || fd_stall !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_mid_busy: observed cnt=%0d stall=%b required 0 0", busy_cnt, fd_stall);
    end
    drive(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (busy_cnt !== 4'd0 || fd_stall !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_mid_after: observed cnt=%0d stall=%b required 0 0", busy_cnt, fd_stall);
    end
  endtask

  task automatic test_back_to_back();
    cur_test = "random";
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 9) == 0));
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_mult_mflo();
    test_div();
    test_load_use();
    test_flush_priority();
    test_flush_busy();
    test_reset_mid_busy();
    test_back_to_back();
    @(posedge clk);
    model_update();
    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL sb_drain: observed %0d pending required 0", sb_q.size());
    end
`ifdef PIPE_STALL_STATS_EN
    n_vec++;
    if (stall_cycles !== 32'(m_stall_cnt) || flush_count !== 16'(m_flush_cnt)) begin
      n_miss++;
      $display("FAIL stats: observed stall=%0d flush=%0d required %0d %0d",
               stall_cycles, flush_count, m_stall_cnt, m_flush_cnt);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
